// File: rtl/rf_pkg.sv
// Shared types and constants for the integer register file.
// Defaults for width/depth, the hard-wired zero index, and word/index types.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_AW    = 5;
  localparam int ZERO_REG = 0;

  typedef logic [RF_AW-1:0]   reg_idx_t;
  typedef logic [RF_XLEN-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero check, write-first bypass,
// and the output register with RST > FLUSH > RE priority.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int AW   = RF_AW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RE,
  input  logic            FLUSH,
  input  logic [AW-1:0]   RADDR,
  input  logic            WE,
  input  logic [AW-1:0]   WADDR,
  input  logic [XLEN-1:0] WDATA,
  input  logic [XLEN-1:0] ARRAY_DATA,
  output logic [XLEN-1:0] RDATA
);

  logic [XLEN-1:0] sel;

  // r0 check must win over a same-index write to r0
  always_comb begin
    sel = ARRAY_DATA;
    priority case (1'b1)
      (RADDR == AW'(ZERO_REG)):  sel = '0;
      (WE && (WADDR == RADDR)): sel = WDATA;
      default:                  sel = ARRAY_DATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RDATA <= '0;
    end else if (FLUSH) begin
      RDATA <= '0;
    end else if (RE) begin
      RDATA <= sel;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Integer register file: one write port, two registered read ports
// with write-first bypass; r0 reads as zero.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = 32,
  parameter int AW   = RF_AW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WE,
  input  logic [AW-1:0]   WADDR,
  input  logic [XLEN-1:0] WDATA,
  input  logic            RE,
  input  logic            FLUSH,
  input  logic [AW-1:0]   RADDR1,
  input  logic [AW-1:0]   RADDR2,
  output logic [XLEN-1:0] RDATA1,
  output logic [XLEN-1:0] RDATA2,
  output logic            RVALID
);

  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] arr1;
  logic [XLEN-1:0] arr2;

  assign arr1 = mem[RADDR1];
  assign arr2 = mem[RADDR2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (WE && (WADDR != AW'(ZERO_REG))) begin
      mem[WADDR] <= WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RVALID <= 1'b0;
    end else if (FLUSH) begin
      RVALID <= 1'b0;
    end else if (RE) begin
      RVALID <= 1'b1;
    end
  end

  rf_read_port #(
    .XLEN(XLEN),
    .AW  (AW)
  ) u_rp1 (
    .CLK       (CLK),
    .RST       (RST),
    .RE        (RE),
    .FLUSH     (FLUSH),
    .RADDR     (RADDR1),
    .WE        (WE),
    .WADDR     (WADDR),
    .WDATA     (WDATA),
    .ARRAY_DATA(arr1),
    .RDATA     (RDATA1)
  );

  rf_read_port #(
    .XLEN(XLEN),
    .AW  (AW)
  ) u_rp2 (
    .CLK       (CLK),
    .RST       (RST),
    .RE        (RE),
    .FLUSH     (FLUSH),
    .RADDR     (RADDR2),
    .WE        (WE),
    .WADDR     (WADDR),
    .WDATA     (WDATA),
    .ARRAY_DATA(arr2),
    .RDATA     (RDATA2)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed and randomized checks for reg_file_2r1w.
// Expected values are hand-computed or come from a small reference model.
module tb_reg_file_2r1w;
  import rf_pkg::*;

  logic     CLK = 1'b0;
  logic     RST, WE, RE, FLUSH;
  reg_idx_t WADDR, RADDR1, RADDR2;
  word_t    WDATA, RDATA1, RDATA2;
  logic     RVALID;

  int checks = 0;
  int errors = 0;

  word_t m_mem [32];
  word_t m_rd1, m_rd2;
  logic  m_rv;

  always #5 CLK = ~CLK;

  reg_file_2r1w dut (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (WE),
    .WADDR (WADDR),
    .WDATA (WDATA),
    .RE    (RE),
    .FLUSH (FLUSH),
    .RADDR1(RADDR1),
    .RADDR2(RADDR2),
    .RDATA1(RDATA1),
    .RDATA2(RDATA2),
    .RVALID(RVALID)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t m_sel(input reg_idx_t a);
    if (a == 0) return '0;
    if (WE && WADDR == a) return WDATA;
    return m_mem[a];
  endfunction

  // advance one edge, updating the reference model alongside
  task automatic tick();
    word_t s1, s2;
    s1 = m_sel(RADDR1);
    s2 = m_sel(RADDR2);
    @(posedge CLK);
    if (RST) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_rd1 = '0; m_rd2 = '0; m_rv = 1'b0;
    end else begin
      if (WE && WADDR != 0) m_mem[WADDR] = WDATA;
      if (FLUSH) begin
        m_rd1 = '0; m_rd2 = '0; m_rv = 1'b0;
      end else if (RE) begin
        m_rd1 = s1; m_rd2 = s2; m_rv = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    RST = 0; WE = 0; RE = 0; FLUSH = 0;
    WADDR = '0; WDATA = '0; RADDR1 = '0; RADDR2 = '0;
  endtask

  initial begin
    idle();
    #2;

    // reset with a write pending
    RST = 1; WE = 1; WADDR = 5'd3; WDATA = 32'hDEADBEEF;
    tick(); tick();
    check("rst_rd1", RDATA1, 32'h0);
    check("rst_rd2", RDATA2, 32'h0);
    check("rst_rv", {31'b0, RVALID}, 32'h0);
    idle(); RE = 1; RADDR1 = 5'd3;
    tick();
    check("rst_r3", RDATA1, 32'h0);
    check("rst_rv1", {31'b0, RVALID}, 32'h1);

    // basic write then read
    idle(); WE = 1; WADDR = 5'd5; WDATA = 32'h12345678;
    tick();
    idle(); RE = 1; RADDR1 = 5'd5; RADDR2 = 5'd0;
    tick();
    check("wr_rd1", RDATA1, 32'h12345678);
    check("wr_rd2", RDATA2, 32'h0);
    check("wr_rv", {31'b0, RVALID}, 32'h1);

    // bypass
    idle(); WE = 1; WADDR = 5'd7; WDATA = 32'hA5A5A5A5;
    RE = 1; RADDR1 = 5'd7; RADDR2 = 5'd7;
    tick();
    check("byp_rd1", RDATA1, 32'hA5A5A5A5);
    check("byp_rd2", RDATA2, 32'hA5A5A5A5);
    idle(); WE = 1; WADDR = 5'd0; WDATA = 32'hFFFFFFFF; RE = 1;
    tick();
    check("byp0_rd1", RDATA1, 32'h0);
    check("byp0_rd2", RDATA2, 32'h0);
    idle(); RE = 1; RADDR1 = 5'd0; RADDR2 = 5'd7;
    tick();
    check("r0_stays", RDATA1, 32'h0);
    check("r7_kept", RDATA2, 32'hA5A5A5A5);

    // stall hold
    idle(); RE = 1; RADDR1 = 5'd5;
    tick();
    check("stl_cap", RDATA1, 32'h12345678);
    idle(); WE = 1; WADDR = 5'd5; WDATA = 32'h0BADF00D; RADDR1 = 5'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_hold", RDATA1, 32'h12345678);
      check("stl_rv", {31'b0, RVALID}, 32'h1);
    end
    idle(); RE = 1; RADDR1 = 5'd5;
    tick();
    check("stl_new", RDATA1, 32'h0BADF00D);

    // flush with concurrent write
    idle(); FLUSH = 1; RE = 1; RADDR1 = 5'd5; RADDR2 = 5'd7;
    WE = 1; WADDR = 5'd9; WDATA = 32'h55;
    tick();
    check("fl_rd1", RDATA1, 32'h0);
    check("fl_rd2", RDATA2, 32'h0);
    check("fl_rv", {31'b0, RVALID}, 32'h0);
    idle(); RE = 1; RADDR1 = 5'd9; RADDR2 = 5'd5;
    tick();
    check("fl_r9", RDATA1, 32'h55);
    check("fl_r5", RDATA2, 32'h0BADF00D);
    check("fl_rv1", {31'b0, RVALID}, 32'h1);

    // reset mid-operation discards write and clears array
    idle(); RST = 1; WE = 1; WADDR = 5'd5; WDATA = 32'h77777777; RE = 1;
    tick();
    idle(); RE = 1; RADDR1 = 5'd5; RADDR2 = 5'd9;
    tick();
    check("rst2_r5", RDATA1, 32'h0);
    check("rst2_r9", RDATA2, 32'h0);

    // random regression against the model
    for (int n = 0; n < 10000; n++) begin
      RST    = ($urandom_range(0, 99) == 0);
      WE     = $urandom_range(0, 1);
      WADDR  = reg_idx_t'($urandom_range(0, 31));
      WDATA  = $urandom;
      RE     = ($urandom_range(0, 3) != 0);
      FLUSH  = ($urandom_range(0, 15) == 0);
      RADDR1 = reg_idx_t'($urandom_range(0, 31));
      RADDR2 = ($urandom_range(0, 7) == 0) ? WADDR
                                           : reg_idx_t'($urandom_range(0, 31));
      tick();
      check("rnd_rd1", RDATA1, m_rd1);
      check("rnd_rd2", RDATA2, m_rd2);
      check("rnd_rv", {31'b0, RVALID}, {31'b0, m_rv});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
